// File: rtl/eth_mac_tx_pause_ctrl_pkg.sv
// Shared definitions for the MAC transmit pause controller: FSM encoding,
// pause-quantum timing default and counter sizing helper.
package eth_mac_tx_pause_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_PAUSED = 2'd2
    } pause_state_t;

    localparam int QUANTA_CYCLES_DEFAULT = 8;
    localparam int QUANTA_WIDTH          = 16;

    // Width of the sub-quantum counter; a one-cycle quantum still needs one bit.
    function automatic int sub_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/eth_mac_tx_pause_ctrl_if.sv
// AXI-stream style bundle between the user TX path, the pause gate and the MAC.
interface eth_mac_tx_pause_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_mac_tx_pause_ctrl_timer.sv
// Pause duration timer: counts quanta, each QUANTA_CYCLES clocks long, and
// flags the final cycle of the pause window.
module eth_pause_timer
    import eth_mac_tx_pause_ctrl_pkg::*;
#(
    parameter int QUANTA_CYCLES = QUANTA_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    run,
    input  logic [QUANTA_WIDTH-1:0] quanta,
    output logic                    expired
);
    localparam int            CW      = sub_cnt_width(QUANTA_CYCLES);
    localparam logic [CW-1:0] CYC_MAX = CW'(QUANTA_CYCLES - 1);

    logic [QUANTA_WIDTH-1:0] quanta_cnt_r;
    logic [CW-1:0]           cycle_cnt_r;

    // Down-count cycles within a quantum, then quanta; both saturate at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            quanta_cnt_r <= {QUANTA_WIDTH{1'b0}};
            cycle_cnt_r  <= {CW{1'b0}};
        end else if (load) begin
            quanta_cnt_r <= quanta;
            cycle_cnt_r  <= CYC_MAX;
        end else if (run) begin
            if (cycle_cnt_r != {CW{1'b0}}) begin
                cycle_cnt_r <= cycle_cnt_r - CW'(1);
            end else if (quanta_cnt_r > 16'd1) begin
                quanta_cnt_r <= quanta_cnt_r - 16'd1;
                cycle_cnt_r  <= CYC_MAX;
            end else begin
                quanta_cnt_r <= {QUANTA_WIDTH{1'b0}};
            end
        end else begin
            quanta_cnt_r <= quanta_cnt_r;
            cycle_cnt_r  <= cycle_cnt_r;
        end
    end

    assign expired = (quanta_cnt_r <= 16'd1) && (cycle_cnt_r == {CW{1'b0}});

endmodule

// File: rtl/eth_mac_tx_pause_ctrl.sv
// Transmit-side 802.3x flow control: passes user frames to the MAC and holds
// transmission at frame boundaries for the requested number of pause quanta.
module eth_mac_tx_pause_ctrl
    import eth_mac_tx_pause_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 1,
    parameter int QUANTA_CYCLES = QUANTA_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    eth_mac_tx_pause_ctrl_if.slave  s_axis,
    eth_mac_tx_pause_ctrl_if.master m_axis,
    input  logic                    pause_enable,
    input  logic                    pause_req,
    input  logic [QUANTA_WIDTH-1:0] pause_quanta,
    output logic                    status_paused,
    output logic                    status_pending
);
    pause_state_t            state_r;
    logic                    pending_r;
    logic                    status_paused_r;
    logic [QUANTA_WIDTH-1:0] stored_quanta_r;

    logic [DATA_WIDTH-1:0]   data_s;
    logic [KEEP_WIDTH-1:0]   keep_s;
    logic [USER_WIDTH-1:0]   user_s;
    logic                    gate_s;
    logic                    xfer_s;
    logic                    accept_s;
    logic                    cancel_s;
    logic                    pend_nxt_s;
    logic [QUANTA_WIDTH-1:0] quanta_nxt_s;
    logic                    start_s;
    logic                    expired_s;

    assign data_s        = s_axis.tdata;
    assign keep_s        = s_axis.tkeep;
    assign user_s        = s_axis.tuser;
    assign m_axis.tdata  = data_s;
    assign m_axis.tkeep  = keep_s;
    assign m_axis.tuser  = user_s;
    assign m_axis.tlast  = s_axis.tlast;

    // Reset also closes the gate so nothing moves while state is being cleared.
    assign gate_s        = (state_r != ST_PAUSED) & ~rst;
    assign m_axis.tvalid = s_axis.tvalid & gate_s;
    assign s_axis.tready = m_axis.tready & gate_s;
    assign xfer_s        = s_axis.tvalid & m_axis.tready & gate_s;

    assign accept_s = pause_req & pause_enable & (pause_quanta != 16'd0);
    assign cancel_s = pause_req & pause_enable & (pause_quanta == 16'd0);

    // Next pending/quanta view and whether a pause window (re)starts this cycle.
    always_comb begin
        pend_nxt_s   = pending_r;
        quanta_nxt_s = stored_quanta_r;
        start_s      = 1'b0;
        if (!pause_enable) begin
            pend_nxt_s = 1'b0;
        end else if (accept_s) begin
            pend_nxt_s = 1'b1;
        end else if (cancel_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pending_r;
        end
        if (accept_s) begin
            quanta_nxt_s = pause_quanta;
        end else begin
            quanta_nxt_s = stored_quanta_r;
        end
        case (state_r)
            ST_IDLE:   start_s = accept_s & ~(xfer_s & ~s_axis.tlast);
            ST_FRAME:  start_s = xfer_s & s_axis.tlast & pend_nxt_s;
            ST_PAUSED: start_s = accept_s;
            default:   start_s = 1'b0;
        endcase
    end

    eth_pause_timer #(
        .QUANTA_CYCLES (QUANTA_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (start_s),
        .run     (state_r == ST_PAUSED),
        .quanta  (quanta_nxt_s),
        .expired (expired_s)
    );

    // Frame-boundary FSM with registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            pending_r       <= 1'b0;
            status_paused_r <= 1'b0;
            stored_quanta_r <= 16'd0;
        end else begin
            stored_quanta_r <= quanta_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r         <= ST_PAUSED;
                        status_paused_r <= 1'b1;
                        pending_r       <= 1'b0;
                    end else if (xfer_s && !s_axis.tlast) begin
                        state_r         <= ST_FRAME;
                        status_paused_r <= 1'b0;
                        pending_r       <= pend_nxt_s;
                    end else begin
                        state_r         <= ST_IDLE;
                        status_paused_r <= 1'b0;
                        pending_r       <= 1'b0;
                    end
                end
                ST_FRAME: begin
                    if (xfer_s && s_axis.tlast) begin
                        state_r         <= start_s ? ST_PAUSED : ST_IDLE;
                        status_paused_r <= start_s;
                        pending_r       <= 1'b0;
                    end else begin
                        state_r         <= ST_FRAME;
                        status_paused_r <= 1'b0;
                        pending_r       <= pend_nxt_s;
                    end
                end
                ST_PAUSED: begin
                    pending_r <= 1'b0;
                    if (!pause_enable || cancel_s) begin
                        state_r         <= ST_IDLE;
                        status_paused_r <= 1'b0;
                    end else if (accept_s) begin
                        state_r         <= ST_PAUSED;
                        status_paused_r <= 1'b1;
                    end else if (expired_s) begin
                        state_r         <= ST_IDLE;
                        status_paused_r <= 1'b0;
                    end else begin
                        state_r         <= ST_PAUSED;
                        status_paused_r <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    status_paused_r <= 1'b0;
                    pending_r       <= 1'b0;
                end
            endcase
        end
    end

    assign status_paused  = status_paused_r;
    assign status_pending = pending_r;

endmodule

// File: doc/eth_mac_tx_pause_ctrl.md
ETH_MAC_TX_PAUSE_CTRL -- requirements
Module: eth_mac_tx_pause_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXI-stream data width (64 only).
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width; bit 0 = bad-frame flag, passed through unchanged.
REQ-004 SHALL have parameter QUANTA_CYCLES, default 8, clock cycles per 512-bit-time pause quantum.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  user TX frame stream.
REQ-008 m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  stream to MAC tx_axis.
REQ-009 pause_enable  input  1  level; 0 disables flow control.
REQ-010 pause_req  input  1  one-cycle pulse, received PAUSE frame.
REQ-011 pause_quanta  input  16  quanta count, valid with pause_req.
REQ-012 status_paused  output  1  high while in PAUSED.
REQ-013 status_pending  output  1  high while a pause waits for end of current frame.

Function
REQ-014 SHALL implement states IDLE (frame boundary), FRAME (frame in progress), PAUSED (transmission held).
REQ-015 Data, keep, last, user SHALL pass combinationally s->m; m_axis_tvalid = s_axis_tvalid & gate; s_axis_tready = m_axis_tready & gate; gate = (state != PAUSED), from registered state only.
REQ-016 Transfer = m_axis_tvalid & m_axis_tready.
REQ-017 IDLE: transfer with tlast=0 -> FRAME; transfer with tlast=1 -> stay IDLE.
REQ-018 FRAME: transfer with tlast=1 -> IDLE, or PAUSED if pending.
REQ-019 Accepted pause_req (pause_enable=1, quanta!=0) in IDLE with no non-last transfer that cycle -> PAUSED next cycle.
REQ-020 Accepted pause_req in FRAME, or in IDLE coinciding with a non-last transfer, SHALL set pending and store quanta; a later pause_req SHALL overwrite stored quanta.
REQ-021 pause_req with quanta=0 SHALL clear pending; in PAUSED -> IDLE next cycle.
REQ-022 PAUSED SHALL last exactly quanta*QUANTA_CYCLES cycles from its first cycle, then -> IDLE.
REQ-023 pause_req in PAUSED with quanta!=0 SHALL restart the count with the new value (replace, not add); PAUSED duration counted from the following cycle.
REQ-024 Quanta counter 16 bits, sub-quantum counter clog2(QUANTA_CYCLES) bits; no wrap; counting stops at zero.
REQ-025 pause_req while pause_enable=0 SHALL be ignored; pause_enable falling SHALL clear pending and exit PAUSED to IDLE next cycle.
REQ-026 A frame in progress SHALL never be stalled by pause; holding occurs only at frame boundaries.
REQ-027 status_paused and status_pending SHALL be registered.

Reset
REQ-028 On rst: state IDLE, pending 0, counters 0, stored quanta 0, status_paused 0, status_pending 0.
REQ-029 During rst s_axis_tready and m_axis_tvalid SHALL be 0.
REQ-030 Reset mid-frame or mid-pause SHALL discard state; no frame recovery.

Structure
REQ-031 State encodings and QUANTA_CYCLES default belong in the shared eth MAC package.
REQ-032 One sub-module natural: eth_pause_timer (load, quanta, cycle/quanta counters, expired flag).

Verification
REQ-033 IDLE, pause_enable=1, pause_req quanta=3 -> status_paused high exactly 24 cycles, tready=0 throughout, then frame passes.
REQ-034 8-beat frame, pause_req quanta=2 at beat 3 -> all 8 beats pass unstalled, status_pending high until tlast, then 16 paused cycles.
REQ-035 PAUSED quanta=10, at cycle 5 pause_req quanta=1 -> paused ends 8 cycles after reload.
REQ-036 PAUSED, pause_req quanta=0 -> IDLE next cycle, tready follows m_axis_tready.
REQ-037 pause_enable=0, pause_req quanta=0xFFFF -> no pause; drop pause_enable during PAUSED -> IDLE next cycle.
REQ-038 rst asserted during PAUSED (quanta=100) -> status_paused 0 cycle after rst deasserts, frames pass.
